// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request/response handshake with fixed wait states.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel, accepted only in IDLE
//   resp_valid/resp_ready/resp_rdata/resp_err     : response channel, held until resp_ready
//   busy                                          : high whenever not IDLE
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned requests answer with resp_err=1, no write, rdata 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
    $error("DEPTH_WORDS must be a power of two >= 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("WAIT_CYCLES must be in 0..15");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept, commit, done, bad;
  logic          unused_addr;
  assign unused_addr = ^req_addr;
  assign accept = state_q == S_IDLE && req_valid;
  // The commit always takes one edge after the counter has expired, which yields
  // WAIT_CYCLES+1 edges from accept to resp_valid, including the zero-wait case.
  assign commit = state_q == S_WAIT && cnt_q == 4'd0;
  assign done   = state_q == S_RESP && resp_ready;
  assign req_ready  = state_q == S_IDLE;
  assign busy       = state_q != S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] off_q;
  logic       err_q;
  assign bad      = |off_q;
  assign resp_err = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      off_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      off_q <= accept ? req_addr[1:0] : off_q;
      err_q <= commit ? bad : err_q;
    end
`else
  assign bad      = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_comb begin
    state_d = accept ? S_WAIT : commit ? S_RESP : done ? S_IDLE : state_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d    = accept ? req_we : we_q;
    idx_d   = accept ? req_addr[AW+1:2] : idx_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = commit ? ((we_q || bad) ? 32'd0 : mem[idx_q]) : rdata_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  // Storage has no reset so contents survive it; an abandoned request never reaches commit.
  always_ff @(posedge clk)
    if (commit && we_q && !bad) mem[idx_q] <= wdata_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, shall set the number of 32-bit storage words; it must be a power of two, at least 2.
REQ-002 Parameter WAIT_CYCLES, default 2, shall set the wait states inserted between request accept and response, legal range 0..15.
REQ-003 Port clk, input, 1, shall be the single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1, shall be the asynchronous, active-low reset (low = reset asserted).
REQ-005 Port req_valid, input, 1, shall indicate that the initiator presents a request.
REQ-006 Port req_ready, output, 1, shall indicate that the responder can accept a request.
REQ-007 Port req_we, input, 1, shall select the operation: 1 = store, 0 = load.
REQ-008 Port req_addr, input, 32, shall carry the byte address.
REQ-009 Port req_wdata, input, 32, shall carry the store data.
REQ-010 Port resp_valid, output, 1, shall indicate that a response is presented.
REQ-011 Port resp_ready, input, 1, shall indicate that the initiator accepts the response.
REQ-012 Port resp_rdata, output, 32, shall carry the load data.
REQ-013 Port resp_err, output, 1, shall flag an errored request.
REQ-014 Port busy, output, 1, shall be high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-016 req_ready shall be 1 only in IDLE, and shall be driven combinationally from state.
REQ-017 Accept: on a rising edge in IDLE with req_valid=1, latch req_we, req_addr and req_wdata, and load the wait counter with WAIT_CYCLES.
REQ-018 After accept, go to WAIT if WAIT_CYCLES>0, otherwise go directly to the commit step of REQ-019.
REQ-019 In WAIT, decrement the counter each cycle; on the edge where it reaches 0, perform the commit and enter RESP.
REQ-020 Commit for a load: capture mem[index] into resp_rdata. Commit for a store: write the latched wdata to mem[index] and set resp_rdata to 0.
REQ-021 index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS words.
REQ-022 Latency: resp_valid shall rise exactly WAIT_CYCLES+1 edges after the accepting edge.
REQ-023 In RESP, resp_valid=1 and resp_rdata/resp_err shall be held stable until an edge with resp_ready=1; the FSM then returns to IDLE.
REQ-024 A new request shall not be accepted on the same edge that completes a response; at most one request is outstanding.
REQ-025 req_valid, req_addr and similar inputs are ignored outside IDLE; no buffering.
REQ-026 A load from an index stored earlier shall return the most recently committed data (read-after-write).

Reset
REQ-027 Reset asserted low shall immediately force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and busy=0; req_ready shall then be 1.
REQ-028 A reset during WAIT shall abandon the request; its store shall not be committed.
REQ-029 Storage contents shall not be cleared by reset.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: a request with addr[1:0]!=0 shall commit no write, return resp_rdata=0 and resp_err=1, with the same latency as a normal request.
REQ-031 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] shall be ignored and resp_err shall be a constant 0.

Verification
REQ-032 WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each resp_valid rises 3 edges after accept; the load returns 0xDEADBEEF with resp_err=0.
REQ-033 WAIT_CYCLES=0, DEPTH_WORDS=256: store 0x0000_0400 data 0x1234, then load 0x0 -> the load returns 0x1234 (wrap), and resp_valid rises 1 edge after accept.
REQ-034 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready stays 0; req_ready rises the cycle after resp_ready=1.
REQ-035 Assert reset mid-WAIT during a store of 0xA5A5A5A5 to 0x20 (prior content 0x1) -> outputs go to their reset values asynchronously, and a later load of 0x20 returns 0x1.
REQ-036 With DMEM_ALIGN_CHECK_EN: store 0x22 -> resp_err=1 and no memory change; without the macro, the same store writes word index 8.
REQ-037 Hold req_valid=1 continuously with back-to-back requests -> exactly one accept per response, with at least one cycle between a response handshake and the next accept.
